// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: byte-in handshake and serial-out signals of the frame transmitter
interface serial_frame_tx_if;
  logic [7:0] dIn;
  logic       load;
  logic       ready;
  logic       sOut;
  logic       done;
  modport master (output dIn, load, input ready, sOut, done);
  modport slave  (input dIn, load, output ready, sOut, done);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames a byte as start, MSB-first data, optional even parity and stop bits
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic       sout_q, sout_d, ready_q, ready_d, done_q, done_d;
  logic       tick;
  always_comb begin
    tick    = cnt_q == '0;
    state_d = state_q;
    cnt_d   = tick ? RELOAD : cnt_q - 8'd1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sout_d  = sout_q;
    case (state_q)
      IDLE: begin
        cnt_d = bus.load ? RELOAD : cnt_q;
        if (bus.load) begin
          state_d = START;
          sr_d    = bus.dIn;
          sout_d  = 1'b0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd7;
        sout_d  = sr_q[7];
      end
      DATA: if (tick) begin
        bit_d = bit_q - 3'd1;
        // the next bit's value is loaded into the flop one boundary ahead
        if (bit_q == 3'd0) begin
          state_d = PARITY_EN ? PARITY : STOP;
          sout_d  = PARITY_EN ? ^sr_q : 1'b1;
        end else
          sout_d = sr_q[bit_q - 3'd1];
      end
      PARITY: if (tick) begin
        state_d = STOP;
        sout_d  = 1'b1;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        sout_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    done_d  = state_d == STOP && cnt_d == '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
  assign bus.sOut  = sout_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: random and directed checks of two transmitter configurations against a frame-list model
module tb_serial_frame_tx;
  typedef logic [1:0] fr_t [$];
  logic clk, rst;
  int checks = 0, errors = 0;
  fr_t qa, qb;
  logic [1:0] ea, eb;
  logic [7:0] sipo = 8'hFF;
  logic [63:0] sv, dv, rv, pv;
  serial_frame_tx_if ifa();
  serial_frame_tx_if ifb();
  serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) ua (.clk(clk), .rst(rst), .bus(ifa.slave));
  serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) ub (.clk(clk), .rst(rst), .bus(ifb.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  // Whole frame as a list of {sOut, done} per cycle
  function automatic fr_t frame(input int p, input int c, input logic [7:0] d);
    fr_t f;
    logic b [$];
    b.push_back(1'b0);
    for (int i = 7; i >= 0; i--) b.push_back(d[i]);
    if (p != 0) b.push_back(^d);
    b.push_back(1'b1);
    for (int i = 0; i < b.size(); i++)
      for (int j = 0; j < c; j++) f.push_back({b[i], i == b.size() - 1 && j == c - 1});
    return f;
  endfunction
  function automatic logic [63:0] expand(input logic [31:0] bits, input int nb, input int c);
    logic [63:0] v = '0;
    for (int i = nb - 1; i >= 0; i--)
      for (int j = 0; j < c; j++) v = {v[62:0], bits[i]};
    return v;
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) qa.delete();
    else if (qa.size() != 0) void'(qa.pop_front());
    else if (ifa.load) qa = frame(1, 4, ifa.dIn);
  always @(posedge clk or negedge rst)
    if (!rst) qb.delete();
    else if (qb.size() != 0) void'(qb.pop_front());
    else if (ifb.load) qb = frame(0, 1, ifb.dIn);
  always @(posedge clk) sipo <= {sipo[6:0], ifb.sOut};
  always @(negedge clk) begin
    ea = qa.size() != 0 ? qa[0] : 2'b10;
    eb = qb.size() != 0 ? qb[0] : 2'b10;
    chk("a_sout", 64'(ifa.sOut), 64'(ea[1]));
    chk("a_done", 64'(ifa.done), 64'(ea[0]));
    chk("a_ready", 64'(ifa.ready), 64'(qa.size() == 0));
    chk("b_sout", 64'(ifb.sOut), 64'(eb[1]));
    chk("b_done", 64'(ifb.done), 64'(eb[0]));
    chk("b_ready", 64'(ifb.ready), 64'(qb.size() == 0));
  end
  task automatic cap(input bit sel, input int n, input int pulse_at);
    sv = '0; dv = '0; rv = '0; pv = '0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      sv = {sv[62:0], sel ? ifb.sOut : ifa.sOut};
      dv = {dv[62:0], sel ? ifb.done : ifa.done};
      rv = {rv[62:0], sel ? ifb.ready : ifa.ready};
      pv = {pv[62:0], sipo[7]};
      if (k == pulse_at) begin
        ifa.load = 1'b1;
        ifa.dIn  = 8'h55;
      end else if (k == pulse_at + 1) ifa.load = 1'b0;
    end
    if (sel) ifb.load = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    ifa.load = 1'b0; ifa.dIn = 8'h00;
    ifb.load = 1'b0; ifb.dIn = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk("rst_sout", 64'(ifa.sOut), 64'd1);
    chk("rst_ready", 64'(ifa.ready), 64'd1);
    chk("rst_done", 64'(ifa.done), 64'd0);
    ifa.load = 1'b1; ifa.dIn = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ifa.load = 1'b0; ifa.dIn = 8'h5A;
    cap(0, 44, 0);
    chk("a5_bits", sv, expand(32'b0_10100101_0_1, 11, 4));
    chk("a5_done", dv, 64'h1);
    chk("a5_ready", rv, 64'h0);
    @(negedge clk);
    chk("a5_idle_ready", 64'(ifa.ready), 64'd1);
    ifa.load = 1'b1; ifa.dIn = 8'h01;
    @(negedge clk);
    ifa.load = 1'b0;
    cap(0, 44, 20);
    chk("01_bits", sv, expand(32'b0_00000001_1_1, 11, 4));
    chk("01_done", dv, 64'h1);
    chk("01_ready", rv, 64'h0);
    sv = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sv = {sv[62:0], ifa.sOut};
    end
    chk("no_extra_frame", sv, 64'hFFF);
    ifb.load = 1'b1; ifb.dIn = 8'hFF;
    @(negedge clk);
    ifb.dIn = 8'h00;
    cap(1, 21, 0);
    chk("b2b_bits", sv, expand(32'b0_11111111_1_1_0_00000000_1, 21, 1));
    chk("b2b_ready", rv, 64'h400);
    chk("b2b_done", dv, 64'h801);
    chk("sipo_delay", 64'(pv[20:12]), 64'(9'b111111110));
    ifa.load = 1'b1; ifa.dIn = 8'h3C;
    @(negedge clk);
    ifa.load = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_sout", 64'(ifa.sOut), 64'd1);
    chk("abort_ready", 64'(ifa.ready), 64'd1);
    chk("abort_done", 64'(ifa.done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ifa.load = 1'b1; ifa.dIn = 8'hC3;
    @(negedge clk);
    ifa.load = 1'b0;
    cap(0, 44, 0);
    chk("c3_bits", sv, expand(32'b0_11000011_0_1, 11, 4));
    chk("c3_done", dv, 64'h1);
    chk("c3_ready", rv, 64'h0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ifa.load = $urandom_range(0, 3) == 0;
      ifa.dIn  = 8'($urandom);
      ifb.load = $urandom_range(0, 2) == 0;
      ifb.dIn  = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    @(negedge clk);
    ifa.load = 1'b0;
    ifb.load = 1'b0;
    repeat (50) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles each frame bit is held on sOut; legal range 1..255.
REQ-002 Parameter: PARITY_EN, default 1, 1 = even-parity bit inserted after data, 0 = no parity bit.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: dIn  input  8  parallel byte to transmit.
REQ-006 Port: load  input  1  byte-valid; transfer occurs on a rising edge with load=1 and ready=1.
REQ-007 Port: ready  output  1  block can accept a byte this cycle.
REQ-008 Port: sOut  output  1  registered serial line driving the downstream serial-in shift register; idle level 1.
REQ-009 Port: done  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-010 The block SHALL be a registered FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-011 The block SHALL capture dIn into an internal 8-bit shift register on the accepting edge; later dIn changes SHALL not affect the frame in flight.
REQ-012 Frame order on sOut SHALL be: start bit 0, dIn[7] down to dIn[0] (MSB first), parity bit (only if PARITY_EN=1), stop bit 1.
REQ-013 Parity bit SHALL equal XOR of the 8 captured data bits (even parity).
REQ-014 Each frame bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-015 A 3-bit data-bit counter SHALL advance at each DATA bit boundary; DATA SHALL exit after bit index 0 completes, to PARITY if PARITY_EN=1, else to STOP.
REQ-016 START SHALL be entered on the edge that accepts the byte, so the start bit appears on sOut in the cycle after acceptance.
REQ-017 Frame length SHALL be (10 + PARITY_EN) * CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle inclusive.
REQ-018 ready SHALL be 1 only in IDLE; load with ready=0 SHALL be ignored and not queued.
REQ-019 done SHALL be 1 only in the last cycle of STOP; the FSM SHALL enter IDLE on the following edge.
REQ-020 Back-to-back: load held high SHALL yield frames separated by exactly one IDLE cycle (sOut=1, ready=1).
REQ-021 In IDLE sOut SHALL be 1; sOut SHALL be driven from a flop, never combinationally from state.
REQ-022 CLKS_PER_BIT=1 SHALL produce one cycle per bit with no skipped or repeated bits.

Reset
REQ-023 rst=0 SHALL immediately, without waiting for clk, force state IDLE, sOut=1, ready=1, done=0, and clear both counters and the data register.
REQ-024 Reset asserted mid-frame SHALL abort the frame; after release, no remnant bits SHALL appear and the next accepted byte SHALL transmit a complete frame.
REQ-025 load during rst=0 SHALL be ignored; the first acceptance SHALL occur on the first rising edge with rst=1.

Verification
REQ-026 Defaults, load 8'hA5 one cycle -> sOut per 4 cycles: 0,1,0,1,0,0,1,0,1, parity 0, stop 1; 44 cycles; done high in cycle 44 only.
REQ-027 Defaults, load 8'h01 -> parity bit 1; ready low from the cycle after acceptance until the cycle after done.
REQ-028 PARITY_EN=0, CLKS_PER_BIT=1, load held high with dIn=8'hFF then 8'h00 -> 10-cycle frames separated by one sOut=1 IDLE cycle; no parity slot.
REQ-029 rst pulsed low mid-DATA of 8'h3C, asynchronous to clk -> sOut=1 and ready=1 within the same cycle; after release, load 8'hC3 -> clean full frame.
REQ-030 load pulsed while ready=0 mid-frame with dIn=8'h55 -> ignored; current frame unchanged, no extra frame afterward.
REQ-031 End-to-end: sOut fed into the 8-bit serial-in serial-out shift register clocked by the same clk with CLKS_PER_BIT=1 -> the start bit emerges at its serial output 8 cycles after entering.
